// File: rtl/data_writer.sv
// Fill stage for the dual-port BRAM: accepts a valid/ready word stream and writes
// up to N words to addresses 0..N-1, keeping a running sum of what was written.
module data_writer #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 7,
  parameter int MEM_SIZE  = 100
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_i,
  input  logic [CNT_WIDTH-1:0]        cnt_val_i,
  input  logic [DWIDTH-1:0]           data_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  output logic [CNT_WIDTH-1:0]        addr_o,
  output logic                        ce_o,
  output logic                        we_o,
  output logic [DWIDTH-1:0]           d_o,
  output logic                        idle_o,
  output logic                        run_o,
  output logic                        done_o,
  output logic [CNT_WIDTH-1:0]        wr_cnt_o,
  output logic [DWIDTH+CNT_WIDTH-1:0] sum_o,
  output logic [1:0]                  state_o
);

  // Stream handshake: a word moves on any cycle where valid_i and ready_o are
  // both high; ready_o is high for every RUN cycle and depends only on state.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] MEM_SIZE_C = CNT_WIDTH'(MEM_SIZE);

  state_t                      state;
  state_t                      state_nx;
  logic [CNT_WIDTH-1:0]        n_q;
  logic [CNT_WIDTH-1:0]        wr_cnt;
  logic [DWIDTH+CNT_WIDTH-1:0] sum;
  logic [CNT_WIDTH-1:0]        n_clamp;
  logic                        start_ok;
  logic                        xfer;

  assign n_clamp  = (cnt_val_i > MEM_SIZE_C) ? MEM_SIZE_C : cnt_val_i;
  assign start_ok = (state == S_IDLE) && start_i;
  assign xfer     = (state == S_RUN) && valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (start_i) state_nx = (n_clamp == '0) ? S_DONE : S_RUN;
      // wr_cnt never passes n_q - 1 because RUN is only entered with n_q >= 1
      S_RUN:  if (valid_i && (wr_cnt == n_q - 1'b1)) state_nx = S_DONE;
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q    <= '0;
      wr_cnt <= '0;
      sum    <= '0;
    end else if (start_ok) begin
      n_q    <= n_clamp;
      wr_cnt <= '0;
      sum    <= '0;
    end else if (xfer) begin
      wr_cnt <= wr_cnt + 1'b1;
      sum    <= sum + {{CNT_WIDTH{1'b0}}, data_i};
    end
  end

  assign idle_o   = (state == S_IDLE);
  assign run_o    = (state == S_RUN);
  assign done_o   = (state == S_DONE);
  assign ready_o  = (state == S_RUN);
  assign ce_o     = xfer;
  assign we_o     = xfer;
  assign addr_o   = wr_cnt;
  assign d_o      = data_i;
  assign wr_cnt_o = wr_cnt;
  assign sum_o    = sum;
  assign state_o  = state;

endmodule
